// File: rtl/jk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jk_pkg
// Brief    : Shared mode encodings for the JK register/counter.
// Revision : 1.0
// ============================================================================
package jk_pkg;

    localparam logic [1:0] MODE_JK   = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage : jk_pkg
`default_nettype wire

// File: rtl/jk_cell.sv
`default_nettype none
// ============================================================================
// Module   : jk_cell
// Brief    : Single JK flip-flop with clock enable and asynchronous reset.
// Revision : 1.0
// ============================================================================
module jk_cell (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic j,
    input  logic k,
    input  logic rst_val,
    output logic q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= rst_val;
        end else if (en) begin
            case ({j, k})
                2'b00:   q <= q;
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                default: q <= ~q;
            endcase
        end
    end

endmodule : jk_cell
`default_nettype wire

// File: rtl/jk_reg_counter.sv
`default_nettype none
// ============================================================================
// Module   : jk_reg_counter
// Brief    : WIDTH-bit register built from JK cells; JK, up, down and load modes.
// Revision : 1.0
// ============================================================================
module jk_reg_counter
    import jk_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    logic [WIDTH-1:0] w_q;
    logic             r_wrap;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        // Mask of all bits below cell i; empty for bit 0, so it always toggles when counting.
        localparam logic [WIDTH-1:0] c_LOW_MASK = (WIDTH'(1) << i) - WIDTH'(1);

        logic w_up_tog;
        logic w_dn_tog;
        logic w_cj;
        logic w_ck;

        assign w_up_tog = &(w_q | ~c_LOW_MASK);
        assign w_dn_tog = ~|(w_q & c_LOW_MASK);

        always_comb begin
            w_cj = j[i];
            w_ck = k[i];
            case (mode)
                MODE_UP: begin
                    w_cj = w_up_tog;
                    w_ck = w_up_tog;
                end
                MODE_DOWN: begin
                    w_cj = w_dn_tog;
                    w_ck = w_dn_tog;
                end
                MODE_LOAD: begin
                    w_cj = j[i];
                    w_ck = ~j[i];
                end
                default: begin
                    w_cj = j[i];
                    w_ck = k[i];
                end
            endcase
        end

        jk_cell u_cell (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .j       (w_cj),
            .k       (w_ck),
            .rst_val (RST_VAL[i]),
            .q       (w_q[i])
        );
    end

    assign tc = en & (((mode == MODE_UP)   & (&w_q)) |
                      ((mode == MODE_DOWN) & ~(|w_q)));

    // A terminal count sampled on an edge is exactly the edge that wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= tc;
        end
    end

    assign q    = w_q;
    assign wrap = r_wrap;

endmodule : jk_reg_counter
`default_nettype wire

// File: tb/tb_jk_reg_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_jk_reg_counter
// Brief    : Directed scoreboard bench for jk_reg_counter (WIDTH=4, RST_VAL=1010).
// Revision : 1.0
// ============================================================================
module tb_jk_reg_counter;
    import jk_pkg::*;

    localparam int         W   = 4;
    localparam logic [3:0] RV  = 4'b1010;

    typedef struct {
        string      tag;
        logic [3:0] q;
        logic       wrap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [3:0] j;
    logic [3:0] k;
    logic [3:0] q;
    logic       tc;
    logic       wrap;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    logic [3:0] mq;

    jk_reg_counter #(.WIDTH(W), .RST_VAL(RV)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .mode (mode),
        .j    (j),
        .k    (k),
        .q    (q),
        .tc   (tc),
        .wrap (wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive one cycle, check tc before the edge, then check q/wrap after it.
    task automatic step(input logic e, input logic [1:0] m, input logic [3:0] jj,
                        input logic [3:0] kk, input string tag);
        logic [3:0] nxt;
        logic       ew;
        logic       etc;
        exp_t       ent;
        en = e; mode = m; j = jj; k = kk;
        #1;
        etc = e && ((m == MODE_UP && mq == 4'hF) || (m == MODE_DOWN && mq == 4'h0));
        chk({tag, ".tc"}, {3'b0, tc}, {3'b0, etc});
        nxt = mq;
        if (e) begin
            case (m)
                MODE_JK:   nxt = (jj & ~mq) | (~kk & mq);
                MODE_UP:   nxt = mq + 4'd1;
                MODE_DOWN: nxt = mq - 4'd1;
                default:   nxt = jj;
            endcase
        end
        ew = etc;
        sb.push_back('{tag, nxt, ew});
        mq = nxt;
        @(posedge clk);
        #1;
        ent = sb.pop_front();
        chk({ent.tag, ".q"},    q,             ent.q);
        chk({ent.tag, ".wrap"}, {3'b0, wrap}, {3'b0, ent.wrap});
    endtask

    // Reset pulse placed between clock edges; q and wrap must react without a clock.
    task automatic rst_pulse(input string tag);
        rst = 1'b1;
        #1;
        chk({tag, ".q"},    q,            RV);
        chk({tag, ".wrap"}, {3'b0, wrap}, 4'b0);
        #2;
        rst = 1'b0;
        mq  = RV;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; en = 1'b0; mode = MODE_JK; j = '0; k = '0;
        mq  = RV;
        #1;
        chk("reset.q",    q,            RV);
        chk("reset.wrap", {3'b0, wrap}, 4'b0);
        chk("reset.tc",   {3'b0, tc},   4'b0);
        @(posedge clk);
        #1;
        chk("reset_held.q", q, RV);
        rst = 1'b0;

        // JK truth table starting from a cleared register.
        step(1'b1, MODE_JK, 4'b0000, 4'b1111, "jk_clr");
        step(1'b1, MODE_JK, 4'b0000, 4'b0000, "jk_hold");
        step(1'b1, MODE_JK, 4'b0000, 4'b0001, "jk_k");
        step(1'b1, MODE_JK, 4'b0001, 4'b0000, "jk_j");
        step(1'b1, MODE_JK, 4'b0001, 4'b0001, "jk_tog0");
        step(1'b1, MODE_JK, 4'b0001, 4'b0001, "jk_tog1");
        step(1'b1, MODE_JK, 4'b1100, 4'b1010, "jk_mix");

        // Up-count wrap.
        step(1'b1, MODE_LOAD, 4'b1101, 4'b0000, "up_ld");
        for (int i = 0; i < 4; i++) step(1'b1, MODE_UP, 4'b0000, 4'b1111, $sformatf("up%0d", i));

        // Down-count wrap.
        step(1'b1, MODE_LOAD, 4'b0010, 4'b1111, "dn_ld");
        for (int i = 0; i < 4; i++) step(1'b1, MODE_DOWN, 4'b1111, 4'b0000, $sformatf("dn%0d", i));

        // Enable hold, including at terminal count.
        step(1'b1, MODE_LOAD, 4'b0101, 4'b0000, "en_ld");
        for (int i = 0; i < 3; i++) step(1'b0, MODE_UP, 4'b1111, 4'b1111, $sformatf("en_hold%0d", i));
        step(1'b1, MODE_UP, 4'b0000, 4'b0000, "en_resume");
        step(1'b1, MODE_LOAD, 4'b1111, 4'b0000, "en_ld_f");
        step(1'b0, MODE_UP, 4'b0000, 4'b0000, "en_hold_tc");
        step(1'b0, MODE_JK, 4'b1111, 4'b1111, "en_hold_jk");

        // Asynchronous reset mid-count, then resume.
        step(1'b1, MODE_LOAD, 4'b0111, 4'b0000, "ar_ld");
        mode = MODE_UP;
        rst_pulse("ar_rst");
        step(1'b1, MODE_UP, 4'b0000, 4'b0000, "ar_resume");

        // Reset discards a wrap pulse already in flight.
        step(1'b1, MODE_LOAD, 4'b1111, 4'b0000, "rw_ld");
        step(1'b1, MODE_UP, 4'b0000, 4'b0000, "rw_wrap");
        rst_pulse("rw_rst");

        // No wrap or tc from LOAD mode extremes.
        step(1'b1, MODE_LOAD, 4'b1111, 4'b0000, "ld_f");
        step(1'b1, MODE_LOAD, 4'b0000, 4'b1111, "ld_0");

        // Mixed modes with pseudo-random operands.
        for (int i = 0; i < 12; i++)
            step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                 4'($urandom), 4'($urandom), $sformatf("rnd%0d", i));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_jk_reg_counter
`default_nettype wire
